vec_cla_add_pipe: RTL and testbench

Two-stage pipelined integer add/sub lane for the vector unit, built on the two-level carry-lookahead scheme. Stage 1 registers operands and forms per-bit generate/propagate signals. Stage 2 produces block G'/P', resolves block carries with element-width segmentation, and registers the sum and per-element carry-outs. It sits between the vector operand read stage and the lane writeback, with valid/ready handshakes on both sides.

---
 rtl/vec_alu_pkg.sv | 16 +
 rtl/carry_unit.sv | 14 +
 rtl/cla_block_gp.sv | 18 +
 rtl/vec_cla_add_pipe.sv | 115 +++++++++++
 tb/tb_vec_cla_add_pipe.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/vec_alu_pkg.sv
// Shared encodings and element-boundary helper for the vector integer ALU lanes.
package vec_alu_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_ADC = 2'b10, OP_SBC = 2'b11} op_e;
  typedef enum logic [1:0] {SEW_E8 = 2'b00, SEW_E16 = 2'b01, SEW_E32 = 2'b10} sew_e;

  // True when byte_idx is the lowest byte of an element; the reserved encoding behaves as e32.
  function automatic logic elem_boundary(input logic [1:0] sew, input int unsigned byte_idx);
    case (sew)
      SEW_E8:  elem_boundary = 1'b1;
      SEW_E16: elem_boundary = (byte_idx % 2) == 0;
      default: elem_boundary = (byte_idx % 4) == 0;
    endcase
  endfunction
endpackage

// File: rtl/carry_unit.sv
// Generic lookahead carry resolution over BITS generate/propagate pairs.
module carry_unit #(
  parameter int BITS = 4
) (
  input  logic [BITS-1:0] g_i,
  input  logic [BITS-1:0] p_i,
  input  logic            c_i,
  output logic [BITS:0]   c_o
);
  always_comb begin
    c_o[0] = c_i;
    for (int i = 0; i < BITS; i++) c_o[i+1] = g_i[i] | (p_i[i] & c_o[i]);
  end
endmodule

// File: rtl/cla_block_gp.sv
// Reduces one lookahead block of bit G/P to block G'/P'.
module cla_block_gp #(
  parameter int W = 4
) (
  input  logic [W-1:0] g_i,
  input  logic [W-1:0] p_i,
  output logic         g_o,
  output logic         p_o
);
  always_comb begin
    g_o = 1'b0;
    p_o = 1'b1;
    for (int i = 0; i < W; i++) begin
      g_o = g_i[i] | (p_i[i] & g_o);
      p_o = p_o & p_i[i];
    end
  end
endmodule

// File: rtl/vec_cla_add_pipe.sv
// Two-stage segmented CLA add/sub lane: S1 registers G/P and carry-ins, S2 registers sum and carry-outs.
module vec_cla_add_pipe
  import vec_alu_pkg::*;
#(
  parameter int LANE_W  = 32,
  parameter int BLOCK_W = 4,
  parameter int TAG_W   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [1:0]           op_i,
  input  logic [1:0]           sew_i,
  input  logic [LANE_W-1:0]    a_i,
  input  logic [LANE_W-1:0]    b_i,
  input  logic [LANE_W/8-1:0]  cin_mask_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANE_W-1:0]    sum_o,
  output logic [LANE_W/8-1:0]  cout_mask_o,
  output logic [TAG_W-1:0]     tag_o
);
  localparam int NBYTES = LANE_W / BYTE_W;
  localparam int NB     = BYTE_W / BLOCK_W;

  logic              s1_valid_q, s2_valid_q, s1_adv, s2_adv, accept;
  logic [LANE_W-1:0] g_d, p_d, g_q, p_q, b_inv, sum_d, sum_q;
  logic [NBYTES-1:0] cin_d, cin_q, cout_d, cout_q;
  logic [1:0]        sew_q;
  logic [TAG_W-1:0]  tag1_q, tag2_q;

  assign s2_adv     = !s2_valid_q | out_ready_i;
  assign s1_adv     = !s1_valid_q | s2_adv;
  assign in_ready_o = s1_adv & !flush_i;
  assign accept     = in_valid_i & in_ready_o;

  // op_i[0] marks the subtracting ops, op_i[1] the ones taking an external carry.
  assign b_inv = op_i[0] ? ~b_i : b_i;
  assign g_d   = a_i & b_inv;
  assign p_d   = a_i ^ b_inv;
  assign cin_d = op_i[1] ? cin_mask_i : {NBYTES{op_i[0]}};

  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    logic          cin_b;
    logic [NB-1:0] bg, bp;
    logic [NB:0]   bc;

    // Byte carry-in comes from the element carry-in at a boundary, else from the byte below.
    if (k == 0) begin : g_first
      assign cin_b = cin_q[0];
    end else begin : g_next
      assign cin_b = elem_boundary(sew_q, k) ? cin_q[k] : g_byte[k-1].bc[NB];
    end

    for (genvar j = 0; j < NB; j++) begin : g_blk
      localparam int LO = k*BYTE_W + j*BLOCK_W;
      logic [BLOCK_W-1:0] c;
      logic               co_unused;

      cla_block_gp #(.W(BLOCK_W)) u_gp (
        .g_i(g_q[LO +: BLOCK_W]), .p_i(p_q[LO +: BLOCK_W]), .g_o(bg[j]), .p_o(bp[j])
      );
      carry_unit #(.BITS(BLOCK_W)) u_l1 (
        .g_i(g_q[LO +: BLOCK_W]), .p_i(p_q[LO +: BLOCK_W]), .c_i(bc[j]), .c_o({co_unused, c})
      );
      assign sum_d[LO +: BLOCK_W] = p_q[LO +: BLOCK_W] ^ c;
    end

    carry_unit #(.BITS(NB)) u_l2 (.g_i(bg), .p_i(bp), .c_i(cin_b), .c_o(bc));
    assign cout_d[k] = elem_boundary(sew_q, k + 1) & bc[NB];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      g_q        <= '0;
      p_q        <= '0;
      cin_q      <= '0;
      sew_q      <= '0;
      tag1_q     <= '0;
      sum_q      <= '0;
      cout_q     <= '0;
      tag2_q     <= '0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
        if (s1_valid_q) begin
          sum_q  <= sum_d;
          cout_q <= cout_d;
          tag2_q <= tag1_q;
        end
      end
      if (s1_adv) s1_valid_q <= accept;
      if (accept) begin
        g_q    <= g_d;
        p_q    <= p_d;
        cin_q  <= cin_d;
        sew_q  <= sew_i;
        tag1_q <= tag_i;
      end
    end
  end

  assign out_valid_o = s2_valid_q;
  assign sum_o       = sum_q;
  assign cout_mask_o = cout_q;
  assign tag_o       = tag2_q;
endmodule

// File: tb/tb_vec_cla_add_pipe.sv
// Randomized and directed bench for vec_cla_add_pipe against an element-wise arithmetic model.
module tb_vec_cla_add_pipe;
  localparam int LANE_W = 32;
  localparam int TAG_W  = 5;
  localparam int NBY    = LANE_W / 8;

  logic              clk = 1'b0;
  logic              rst_ni, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [1:0]        op_i, sew_i;
  logic [LANE_W-1:0] a_i, b_i, sum_o;
  logic [NBY-1:0]    cin_mask_i, cout_mask_o;
  logic [TAG_W-1:0]  tag_i, tag_o;

  vec_cla_add_pipe #(.LANE_W(LANE_W), .BLOCK_W(4), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .op_i(op_i), .sew_i(sew_i), .a_i(a_i), .b_i(b_i), .cin_mask_i(cin_mask_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .sum_o(sum_o), .cout_mask_o(cout_mask_o),
    .tag_o(tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANE_W-1:0] sum;
    logic [NBY-1:0]    cout;
    logic [TAG_W-1:0]  tag;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Element-wise reference: plain integer add of each element, carry is bit ew of the result.
  function automatic void model(input logic [1:0] op, input logic [1:0] sew,
                                input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b,
                                input logic [NBY-1:0] cm,
                                output logic [LANE_W-1:0] s, output logic [NBY-1:0] co);
    int ew;
    longint unsigned m, av, bv, cin, r;
    s  = '0;
    co = '0;
    ew = (sew == 2'd0) ? 8 : (sew == 2'd1) ? 16 : 32;
    m  = (64'd1 << ew) - 1;
    for (int lo = 0; lo < LANE_W; lo += ew) begin
      av = (64'(a) >> lo) & m;
      bv = (64'(b) >> lo) & m;
      if (op == 2'd1 || op == 2'd3) bv = ~bv & m;
      cin = (op == 2'd0) ? 64'd0 : (op == 2'd1) ? 64'd1 : 64'(cm[lo/8]);
      r = av + bv + cin;
      s = s | LANE_W'((r & m) << lo);
      co[(lo + ew)/8 - 1] = ((r >> ew) & 64'd1) != 0;
    end
  endfunction

  // Scoreboard: push at accept, compare head whenever a result is shown, pop on transfer.
  initial begin
    logic [LANE_W-1:0] es;
    logic [NBY-1:0]    ec;
    exp_t              e;
    forever begin
      @(negedge clk);
      if (!rst_ni || flush_i) begin
        q.delete();
      end else begin
        if (out_valid_o) begin
          if (q.size() == 0) chk("stale_valid", {63'b0, out_valid_o}, 64'd0);
          else begin
            chk("sb_sum", sum_o, q[0].sum);
            chk("sb_cout", cout_mask_o, q[0].cout);
            chk("sb_tag", tag_o, q[0].tag);
            if (out_ready_i) void'(q.pop_front());
          end
        end
        if (in_valid_i && in_ready_o) begin
          model(op_i, sew_i, a_i, b_i, cin_mask_i, es, ec);
          e.sum = es; e.cout = ec; e.tag = tag_i;
          q.push_back(e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [1:0] sew, input logic [LANE_W-1:0] a,
                       input logic [LANE_W-1:0] b, input logic [NBY-1:0] cm, input logic [TAG_W-1:0] tg);
    in_valid_i = 1'b1; op_i = op; sew_i = sew; a_i = a; b_i = b; cin_mask_i = cm; tag_i = tg;
  endtask

  task automatic directed(input string nm, input logic [1:0] op, input logic [1:0] sew,
                          input logic [LANE_W-1:0] a, input logic [LANE_W-1:0] b, input logic [NBY-1:0] cm,
                          input logic [LANE_W-1:0] xs, input logic [NBY-1:0] xc);
    logic [LANE_W-1:0] ms;
    logic [NBY-1:0]    mc;
    model(op, sew, a, b, cm, ms, mc);
    chk({nm, "_model_sum"}, ms, xs);
    chk({nm, "_model_cout"}, mc, xc);
    out_ready_i = 1'b1;
    drive(op, sew, a, b, cm, 5'd7);
    chk({nm, "_in_ready"}, in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
    chk({nm, "_lat_early"}, out_valid_o, 0);
    tick();
    chk({nm, "_valid"}, out_valid_o, 1);
    chk({nm, "_sum"}, sum_o, xs);
    chk({nm, "_cout"}, cout_mask_o, xc);
    tick();
  endtask

  function automatic logic [LANE_W-1:0] rand_opnd();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return LANE_W'($urandom_range(0, 3));
      default: return LANE_W'($urandom);
    endcase
  endfunction

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    op_i = '0; sew_i = '0; a_i = '0; b_i = '0; cin_mask_i = '0; tag_i = '0;
    tick(); tick();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_sum", sum_o, 0);
    chk("rst_cout", cout_mask_o, 0);
    chk("rst_tag", tag_o, 0);
    rst_ni = 1'b1;
    tick();

    directed("e32_add", 2'b00, 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 4'b0000, 32'h0000_0000, 4'b1000);
    directed("e8_add",  2'b00, 2'b00, 32'h80FF_7F01, 32'h8001_7F01, 4'b0000, 32'h0000_FE02, 4'b1100);
    directed("e16_sub", 2'b01, 2'b01, 32'h0005_0003, 32'h0001_0004, 4'b0000, 32'h0004_FFFF, 4'b1000);
    directed("e16_adc", 2'b10, 2'b01, 32'h0000_FFFF, 32'h0000_0000, 4'b0101, 32'h0001_0000, 4'b0010);
    directed("rsv_sub", 2'b01, 2'b11, 32'h0000_0000, 32'h0000_0001, 4'b0000, 32'hFFFF_FFFF, 4'b0000);

    // Back-pressure: two ops fill S1/S2, third waits, then drain in order.
    out_ready_i = 1'b0;
    drive(2'b00, 2'b00, 32'h0102_0304, 32'h1111_1111, 4'h0, 5'd1);
    tick();
    drive(2'b01, 2'b01, 32'h0000_0010, 32'h0000_0001, 4'h0, 5'd2);
    tick();
    drive(2'b10, 2'b10, 32'h7FFF_FFFF, 32'h0000_0000, 4'h1, 5'd3);
    chk("bp_in_ready_low", in_ready_o, 0);
    tick();
    chk("bp_in_ready_hold", in_ready_o, 0);
    chk("bp_tag1_valid", out_valid_o, 1);
    chk("bp_tag1", tag_o, 1);
    out_ready_i = 1'b1;
    tick();
    in_valid_i = 1'b0;
    chk("bp_tag2_valid", out_valid_o, 1);
    chk("bp_tag2", tag_o, 2);
    tick();
    chk("bp_tag3_valid", out_valid_o, 1);
    chk("bp_tag3", tag_o, 3);
    chk("bp_tag3_sum", sum_o, 32'h8000_0000);
    tick();
    chk("bp_empty", out_valid_o, 0);

    // Flush with both stages full and a pending input.
    out_ready_i = 1'b0;
    drive(2'b00, 2'b00, 32'h1, 32'h1, 4'h0, 5'd4);
    tick();
    drive(2'b00, 2'b00, 32'h2, 32'h2, 4'h0, 5'd5);
    tick();
    drive(2'b00, 2'b00, 32'h3, 32'h3, 4'h0, 5'd6);
    flush_i = 1'b1;
    chk("flush_in_ready", in_ready_o, 0);
    tick();
    flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
    chk("flush_valid", out_valid_o, 0);
    tick();
    chk("flush_no_accept", out_valid_o, 0);

    // Reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      drive(2'($urandom), 2'($urandom), rand_opnd(), rand_opnd(), NBY'($urandom), TAG_W'(i));
      tick();
    end
    rst_ni = 1'b0;
    tick();
    chk("mrst_valid", out_valid_o, 0);
    chk("mrst_sum", sum_o, 0);
    chk("mrst_cout", cout_mask_o, 0);
    chk("mrst_tag", tag_o, 0);
    rst_ni = 1'b1; in_valid_i = 1'b0;
    tick();
    chk("mrst_no_stale1", out_valid_o, 0);
    tick();
    chk("mrst_no_stale2", out_valid_o, 0);

    // Random traffic with back-pressure, sew changes and occasional flush.
    for (int i = 0; i < 800; i++) begin
      in_valid_i  = ($urandom_range(0, 9) < 7);
      op_i        = 2'($urandom);
      sew_i       = 2'($urandom);
      a_i         = rand_opnd();
      b_i         = rand_opnd();
      cin_mask_i  = NBY'($urandom);
      tag_i       = TAG_W'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      flush_i     = ($urandom_range(0, 49) == 0);
      tick();
    end
    in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid_o); i++) tick();
    chk("drain_queue", q.size(), 0);
    chk("drain_valid", out_valid_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
